// File: rtl/fm_pkg.sv
// Shared state encoding and Wishbone register map for the FM sweep sequencer.
package fm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_DWELL    = 3'd3,
        ST_DONE     = 3'd4
    } fm_state_e;

    localparam logic [1:0] ADDR_CARRIER   = 2'd0;
    localparam logic [1:0] ADDR_MOD_FREQ  = 2'd1;
    localparam logic [1:0] ADDR_DEVIATION = 2'd2;

endpackage

// File: rtl/wb_single_write.sv
// One-write Wishbone master: raises cyc/stb on launch, drops stb on acceptance,
// drops cyc on ack or after ACK_TIMEOUT cycles without ack.
module wb_single_write #(
    parameter int DATA_WIDTH  = 32,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  launch,
    input  logic [DATA_WIDTH-1:0] launch_data,
    input  logic                  wb_ack,
    input  logic                  wb_stall,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_we,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  accepted,
    output logic                  acked,
    output logic                  timed_out
);

    localparam int TW = ($clog2(ACK_TIMEOUT + 1) < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    logic [TW-1:0] wait_cnt;

    // An ack only counts once the strobe has been accepted, either earlier
    // (stb already low) or on this very edge (stall low).
    assign accepted  = wb_stb & ~wb_stall;
    assign acked     = wb_cyc & wb_ack & (~wb_stb | ~wb_stall);
    assign timed_out = wb_cyc & ~wb_stb & ~wb_ack & (wait_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_data  <= '0;
            wait_cnt <= '0;
        end else if (launch) begin
            wb_cyc   <= 1'b1;
            wb_stb   <= 1'b1;
            wb_we    <= 1'b1;
            wb_data  <= launch_data;
            wait_cnt <= '0;
        end else if (acked || timed_out) begin
            wb_cyc <= 1'b0;
            wb_stb <= 1'b0;
            wb_we  <= 1'b0;
        end else if (accepted) begin
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wait_cnt <= '0;
        end else if (wb_cyc && !wb_stb) begin
            wait_cnt <= wait_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/fm_sweep_sequencer.sv
// Sweeps a carrier increment from a start value by a signed delta, writing each
// value to the carrier register over Wishbone with a programmable dwell between.
module fm_sweep_sequencer
    import fm_pkg::*;
#(
    parameter int         ACC_WIDTH    = 32,
    parameter int         COUNT_WIDTH  = 16,
    parameter int         DWELL_WIDTH  = 24,
    parameter int         ACK_TIMEOUT  = 15,
    parameter logic [1:0] CARRIER_ADDR = ADDR_CARRIER
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [ACC_WIDTH-1:0]   i_start_inc,
    input  logic [ACC_WIDTH-1:0]   i_step_inc,
    input  logic [COUNT_WIDTH-1:0] i_num_steps,
    input  logic [DWELL_WIDTH-1:0] i_dwell,
    output logic                   o_wb_cyc,
    output logic                   o_wb_stb,
    output logic                   o_wb_we,
    output logic [1:0]             o_wb_addr,
    output logic [ACC_WIDTH-1:0]   o_wb_data,
    input  logic                   i_wb_ack,
    input  logic                   i_wb_stall,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error,
    output logic [COUNT_WIDTH-1:0] o_step_idx
);

    fm_state_e state, next_state;

    logic [ACC_WIDTH-1:0]   cur_inc;
    logic [ACC_WIDTH-1:0]   step_q;
    logic [ACC_WIDTH-1:0]   launch_data;
    logic [COUNT_WIDTH-1:0] num_steps_q;
    logic [COUNT_WIDTH-1:0] step_idx;
    logic [DWELL_WIDTH-1:0] dwell_q;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic                   abort_q;
    logic                   error_q;
    logic                   launch;
    logic                   bus_accept;
    logic                   bus_ack;
    logic                   bus_timeout;
    logic                   last_step;
    logic                   abort_now;
    logic                   dwell_over;

    assign last_step  = (step_idx == num_steps_q - COUNT_WIDTH'(1));
    assign abort_now  = abort_q | i_abort;
    assign dwell_over = (dwell_cnt == dwell_q - DWELL_WIDTH'(1));

    always_comb begin
        next_state  = state;
        launch      = 1'b0;
        launch_data = cur_inc;
        case (state)
            ST_IDLE: begin
                if (!i_abort && i_start) begin
                    if (i_num_steps != '0) begin
                        next_state  = ST_WRITE;
                        launch      = 1'b1;
                        launch_data = i_start_inc;
                    end else begin
                        next_state = ST_DONE;
                    end
                end
            end
            ST_WRITE, ST_WAIT_ACK: begin
                // An abort never cuts a bus cycle short; it only decides
                // where we go once the cycle has finished.
                if (bus_timeout) begin
                    next_state = ST_IDLE;
                end else if (bus_ack) begin
                    if (abort_now) begin
                        next_state = ST_IDLE;
                    end else if (last_step) begin
                        next_state = ST_DONE;
                    end else if (dwell_q != '0) begin
                        next_state = ST_DWELL;
                    end else begin
                        next_state  = ST_WRITE;
                        launch      = 1'b1;
                        launch_data = cur_inc + step_q;
                    end
                end else if (state == ST_WRITE && bus_accept) begin
                    next_state = ST_WAIT_ACK;
                end
            end
            ST_DWELL: begin
                if (i_abort) begin
                    next_state = ST_IDLE;
                end else if (dwell_over) begin
                    next_state = ST_WRITE;
                    launch     = 1'b1;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            cur_inc     <= '0;
            step_q      <= '0;
            num_steps_q <= '0;
            dwell_q     <= '0;
            dwell_cnt   <= '0;
            step_idx    <= '0;
            abort_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE: begin
                    if (!i_abort && i_start && i_num_steps != '0) begin
                        cur_inc     <= i_start_inc;
                        step_q      <= i_step_inc;
                        num_steps_q <= i_num_steps;
                        dwell_q     <= i_dwell;
                        step_idx    <= '0;
                        abort_q     <= 1'b0;
                        error_q     <= 1'b0;
                    end
                end
                ST_WRITE, ST_WAIT_ACK: begin
                    if (i_abort) begin
                        abort_q <= 1'b1;
                    end
                    if (bus_timeout) begin
                        error_q <= 1'b1;
                    end else if (bus_ack && !abort_now && !last_step) begin
                        cur_inc   <= cur_inc + step_q;
                        step_idx  <= step_idx + COUNT_WIDTH'(1);
                        dwell_cnt <= '0;
                    end
                end
                ST_DWELL: dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
                default: ;
            endcase
        end
    end

    wb_single_write #(
        .DATA_WIDTH (ACC_WIDTH),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_wb (
        .clk        (i_clk),
        .reset      (i_reset),
        .launch     (launch),
        .launch_data(launch_data),
        .wb_ack     (i_wb_ack),
        .wb_stall   (i_wb_stall),
        .wb_cyc     (o_wb_cyc),
        .wb_stb     (o_wb_stb),
        .wb_we      (o_wb_we),
        .wb_data    (o_wb_data),
        .accepted   (bus_accept),
        .acked      (bus_ack),
        .timed_out  (bus_timeout)
    );

    assign o_wb_addr  = CARRIER_ADDR;
    assign o_busy     = (state != ST_IDLE);
    assign o_done     = (state == ST_DONE);
    assign o_error    = error_q;
    assign o_step_idx = step_idx;

endmodule

// File: tb/tb_fm_sweep_sequencer.sv
// Directed bench for fm_sweep_sequencer with a scripted Wishbone slave that
// records accepted writes, stall lengths, dwell gaps and ack-wait lengths.
module tb_fm_sweep_sequencer;

    localparam int AW = 32;
    localparam int CW = 16;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] start_inc = '0;
    logic [AW-1:0] step_inc = '0;
    logic [CW-1:0] num_steps = '0;
    logic [DW-1:0] dwell = '0;
    logic          wb_cyc, wb_stb, wb_we;
    logic [1:0]    wb_addr;
    logic [AW-1:0] wb_data;
    logic          wb_ack, wb_stall;
    logic          busy, done, error;
    logic [CW-1:0] step_idx;

    int compared = 0;
    int mismatched = 0;

    // slave configuration
    bit ack_mode = 1'b1;
    bit early_ack = 1'b0;
    int stall_on_write = 0;
    int stall_cycles = 0;

    // slave / monitor state
    int ncyc = 0, done_cnt = 0, cyc_cnt = 0, write_seen = 0, stall_left = 0;
    int stb_len = 0, wait_len = 0, unstable = 0, last_ack_n = 0;
    bit have_ack = 0, prev_stb = 0, prev_wait = 0, ack_next = 0, ack_pulse = 0;
    bit cur_wait = 0, early = 0, hung = 0;
    logic [AW-1:0] rise_data = '0;
    logic [AW-1:0] acc_q[$];
    logic [AW-1:0] exp_q[$];
    int len_q[$];
    int gap_q[$];
    int wait_q[$];

    fm_sweep_sequencer dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_abort    (abort),
        .i_start_inc(start_inc),
        .i_step_inc (step_inc),
        .i_num_steps(num_steps),
        .i_dwell    (dwell),
        .o_wb_cyc   (wb_cyc),
        .o_wb_stb   (wb_stb),
        .o_wb_we    (wb_we),
        .o_wb_addr  (wb_addr),
        .o_wb_data  (wb_data),
        .i_wb_ack   (wb_ack),
        .i_wb_stall (wb_stall),
        .o_busy     (busy),
        .o_done     (done),
        .o_error    (error),
        .o_step_idx (step_idx)
    );

    always #5 clk = ~clk;

    // Slave: decides stall/ack at each falling edge for the next rising edge.
    initial begin
        wb_ack = 1'b0;
        wb_stall = 1'b0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (done === 1'b1) done_cnt++;
            if (wb_cyc === 1'b1) cyc_cnt++;
            cur_wait = (wb_cyc === 1'b1) && (wb_stb !== 1'b1);
            if (cur_wait) begin
                wait_len++;
            end else if (prev_wait) begin
                wait_q.push_back(wait_len);
                wait_len = 0;
            end
            ack_pulse = ack_next;
            ack_next = 1'b0;
            early = 1'b0;
            if (wb_stb === 1'b1) begin
                if (!prev_stb) begin
                    stall_left = (write_seen == stall_on_write) ? stall_cycles : 0;
                    write_seen++;
                    stb_len = 0;
                    rise_data = wb_data;
                    if (have_ack) begin
                        gap_q.push_back(ncyc - last_ack_n - 1);
                        have_ack = 1'b0;
                    end
                end
                stb_len++;
                if (wb_data !== rise_data) unstable++;
                if (stall_left > 0) begin
                    wb_stall = 1'b1;
                    stall_left--;
                    early = early_ack;
                end else begin
                    wb_stall = 1'b0;
                    acc_q.push_back(wb_data);
                    len_q.push_back(stb_len);
                    if (ack_mode) ack_next = 1'b1;
                end
            end else begin
                wb_stall = 1'b0;
            end
            wb_ack = ack_pulse | early;
            if (ack_pulse) begin
                last_ack_n = ncyc;
                have_ack = 1'b1;
            end
            prev_stb = (wb_stb === 1'b1);
            prev_wait = cur_wait;
        end
    end

    task automatic step_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        done_cnt = 0; cyc_cnt = 0; write_seen = 0; unstable = 0;
        have_ack = 1'b0; wait_len = 0;
        acc_q.delete(); exp_q.delete(); len_q.delete(); gap_q.delete(); wait_q.delete();
    endtask

    task automatic do_start(input logic [AW-1:0] si, input logic [AW-1:0] st,
                            input logic [CW-1:0] n, input logic [DW-1:0] d);
        start_inc = si; step_inc = st; num_steps = n; dwell = d;
        start = 1'b1;
        step_neg();
        start = 1'b0;
    endtask

    task automatic wait_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (busy === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
            step_neg();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step_neg();
        compared++; if (wb_cyc !== 1'b0) begin mismatched++; $display("FAIL reset_cyc: got %b need 0", wb_cyc); end
        compared++; if (wb_stb !== 1'b0) begin mismatched++; $display("FAIL reset_stb: got %b need 0", wb_stb); end
        compared++; if (wb_we !== 1'b0) begin mismatched++; $display("FAIL reset_we: got %b need 0", wb_we); end
        compared++; if (wb_data !== '0) begin mismatched++; $display("FAIL reset_data: got %h need 0", wb_data); end
        compared++; if (wb_addr !== 2'd0) begin mismatched++; $display("FAIL reset_addr: got %0d need 0", wb_addr); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b need 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b need 0", done); end
        compared++; if (error !== 1'b0) begin mismatched++; $display("FAIL reset_error: got %b need 0", error); end
        compared++; if (step_idx !== '0) begin mismatched++; $display("FAIL reset_idx: got %0d need 0", step_idx); end
        reset = 1'b0;
        step_neg();
    endtask

    task automatic test_basic_sweep();
        clear_mon();
        do_start(32'h0044_4444, 32'h0000_1000, 16'd3, 24'd4);
        // config changes and a second start while busy must have no effect
        start_inc = 32'hDEAD_BEEF; step_inc = 32'h1; num_steps = 16'd7; dwell = 24'd0;
        repeat (3) step_neg();
        start = 1'b1;
        step_neg();
        start = 1'b0;
        wait_idle(hung);
        compared++; if (hung) begin mismatched++; $display("FAIL basic_idle: busy=%b need 0", busy); end
        exp_q.push_back(32'h0044_4444); exp_q.push_back(32'h0044_5444); exp_q.push_back(32'h0044_6444);
        compared++; if (acc_q.size() != 3) begin mismatched++; $display("FAIL basic_count: got %0d writes need 3", acc_q.size()); end
        foreach (exp_q[i]) begin
            compared++;
            if (i >= acc_q.size() || acc_q[i] !== exp_q[i]) begin
                mismatched++;
                $display("FAIL basic_write%0d: got %h need %h", i, (i < acc_q.size()) ? acc_q[i] : 'x, exp_q[i]);
            end
        end
        compared++; if (gap_q.size() != 2 || gap_q[0] != 4 || gap_q[1] != 4) begin
            mismatched++; $display("FAIL basic_dwell_gap: got %0d gaps, first %0d, need two gaps of 4", gap_q.size(), (gap_q.size() > 0) ? gap_q[0] : -1);
        end
        compared++; if (done_cnt != 1) begin mismatched++; $display("FAIL basic_done: got %0d pulses need 1", done_cnt); end
        compared++; if (step_idx !== 16'd2) begin mismatched++; $display("FAIL basic_idx: got %0d need 2", step_idx); end
        compared++; if (error !== 1'b0) begin mismatched++; $display("FAIL basic_error: got %b need 0", error); end
    endtask

    task automatic test_stall();
        clear_mon();
        stall_on_write = 0; stall_cycles = 3; early_ack = 1'b1;
        do_start(32'h0000_0010, 32'h0000_0001, 16'd2, 24'd0);
        wait_idle(hung);
        stall_cycles = 0; early_ack = 1'b0;
        compared++; if (hung) begin mismatched++; $display("FAIL stall_idle: busy=%b need 0", busy); end
        compared++; if (len_q.size() != 2 || len_q[0] != 4 || len_q[1] != 1) begin
            mismatched++; $display("FAIL stall_stb_len: got %0d entries, first %0d, need 4 then 1", len_q.size(), (len_q.size() > 0) ? len_q[0] : -1);
        end
        compared++; if (unstable != 0) begin mismatched++; $display("FAIL stall_data_stable: got %0d changes need 0", unstable); end
        compared++; if (acc_q.size() != 2 || acc_q[0] !== 32'h10 || acc_q[1] !== 32'h11) begin
            mismatched++; $display("FAIL stall_writes: got %0d writes, need 00000010 then 00000011", acc_q.size());
        end
        compared++; if (done_cnt != 1) begin mismatched++; $display("FAIL stall_done: got %0d pulses need 1", done_cnt); end
    endtask

    task automatic test_wrap();
        clear_mon();
        do_start(32'hFFFF_F000, 32'h0000_2000, 16'd2, 24'd0);
        wait_idle(hung);
        compared++; if (hung) begin mismatched++; $display("FAIL wrap_idle: busy=%b need 0", busy); end
        compared++; if (acc_q.size() != 2 || acc_q[1] !== 32'h0000_1000) begin
            mismatched++; $display("FAIL wrap_write1: got %h (%0d writes) need 00001000", (acc_q.size() > 1) ? acc_q[1] : 'x, acc_q.size());
        end
        compared++; if (gap_q.size() != 1 || gap_q[0] != 0) begin mismatched++; $display("FAIL wrap_no_dwell: got %0d gaps need one gap of 0", gap_q.size()); end
    endtask

    task automatic test_timeout();
        clear_mon();
        ack_mode = 1'b0;
        do_start(32'h0000_5000, 32'h0000_0010, 16'd3, 24'd0);
        wait_idle(hung);
        ack_mode = 1'b1;
        compared++; if (hung) begin mismatched++; $display("FAIL tmo_idle: busy=%b need 0", busy); end
        compared++; if (error !== 1'b1) begin mismatched++; $display("FAIL tmo_error: got %b need 1", error); end
        compared++; if (done_cnt != 0) begin mismatched++; $display("FAIL tmo_done: got %0d pulses need 0", done_cnt); end
        compared++; if (wait_q.size() != 1 || wait_q[0] != 15) begin
            mismatched++; $display("FAIL tmo_wait_len: got %0d (%0d cycles) need one wait of 15", wait_q.size(), (wait_q.size() > 0) ? wait_q[0] : -1);
        end
        compared++; if (acc_q.size() != 1) begin mismatched++; $display("FAIL tmo_writes: got %0d need 1", acc_q.size()); end
        clear_mon();
        do_start(32'h0000_7000, 32'h0, 16'd1, 24'd0);
        compared++; if (error !== 1'b0) begin mismatched++; $display("FAIL tmo_error_clear: got %b need 0", error); end
        wait_idle(hung);
        compared++; if (done_cnt != 1 || acc_q.size() != 1 || acc_q[0] !== 32'h7000) begin
            mismatched++; $display("FAIL tmo_recover: got %0d done, %0d writes, need 1 and 1 write of 00007000", done_cnt, acc_q.size());
        end
    endtask

    task automatic test_zero_steps();
        clear_mon();
        do_start(32'h0000_0099, 32'h1, 16'd0, 24'd3);
        compared++; if (done !== 1'b1 || busy !== 1'b1) begin mismatched++; $display("FAIL zero_done_pulse: got done=%b busy=%b need 1 1", done, busy); end
        step_neg();
        compared++; if (done !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL zero_back_idle: got done=%b busy=%b need 0 0", done, busy); end
        compared++; if (cyc_cnt != 0) begin mismatched++; $display("FAIL zero_no_cyc: got %0d cyc cycles need 0", cyc_cnt); end
        compared++; if (done_cnt != 1) begin mismatched++; $display("FAIL zero_done_count: got %0d need 1", done_cnt); end
    endtask

    task automatic test_abort_dwell();
        bit found;
        clear_mon();
        found = 1'b0;
        do_start(32'h0000_0100, 32'h0000_0010, 16'd5, 24'd10);
        for (int k = 0; k < 60; k++) begin
            if (step_idx === 16'd1 && wb_cyc === 1'b0) begin
                found = 1'b1;
                break;
            end
            step_neg();
        end
        compared++; if (!found) begin mismatched++; $display("FAIL abort_dwell_reach: idx=%0d cyc=%b need idx 1 in dwell", step_idx, wb_cyc); end
        abort = 1'b1;
        step_neg();
        abort = 1'b0;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL abort_dwell_busy: got %b need 0", busy); end
        repeat (12) step_neg();
        compared++; if (step_idx !== 16'd1) begin mismatched++; $display("FAIL abort_dwell_idx: got %0d need 1", step_idx); end
        compared++; if (done_cnt != 0 || acc_q.size() != 1) begin
            mismatched++; $display("FAIL abort_dwell_quiet: got %0d done %0d writes need 0 and 1", done_cnt, acc_q.size());
        end
    endtask

    task automatic test_abort_write();
        clear_mon();
        stall_on_write = 0; stall_cycles = 3;
        do_start(32'h0000_0200, 32'h0000_0010, 16'd3, 24'd0);
        abort = 1'b1;
        step_neg();
        abort = 1'b0;
        wait_idle(hung);
        stall_cycles = 0;
        compared++; if (hung) begin mismatched++; $display("FAIL abort_write_idle: busy=%b need 0", busy); end
        compared++; if (acc_q.size() != 1 || acc_q[0] !== 32'h200) begin
            mismatched++; $display("FAIL abort_write_completes: got %0d writes need one of 00000200", acc_q.size());
        end
        compared++; if (wait_q.size() != 1 || wait_q[0] != 1 || done_cnt != 0) begin
            mismatched++; $display("FAIL abort_write_acked: got %0d waits, %0d done, need one 1-cycle wait and 0 done", wait_q.size(), done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        clear_mon();
        found = 1'b0;
        ack_mode = 1'b0;
        do_start(32'h0000_1234, 32'h1, 16'd2, 24'd0);
        for (int k = 0; k < 20; k++) begin
            if (wb_cyc === 1'b1 && wb_stb === 1'b0) begin
                found = 1'b1;
                break;
            end
            step_neg();
        end
        compared++; if (!found) begin mismatched++; $display("FAIL rst_mid_reach: cyc=%b stb=%b need wait-ack phase", wb_cyc, wb_stb); end
        reset = 1'b1;
        step_neg();
        compared++; if ({wb_cyc, wb_stb, wb_we, done, error, busy} !== 6'b0) begin
            mismatched++; $display("FAIL rst_mid_ctrl: got cyc/stb/we/done/err/busy=%b need 000000", {wb_cyc, wb_stb, wb_we, done, error, busy});
        end
        compared++; if (wb_data !== '0 || step_idx !== '0 || wb_addr !== 2'd0) begin
            mismatched++; $display("FAIL rst_mid_data: got data=%h idx=%0d addr=%0d need 0 0 0", wb_data, step_idx, wb_addr);
        end
        reset = 1'b0;
        ack_mode = 1'b1;
        step_neg();
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_stall();
        test_wrap();
        test_timeout();
        test_zero_steps();
        test_abort_dwell();
        test_abort_write();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fm_sweep_sequencer.md
FM_SWEEP_SEQUENCER -- requirements
Module: fm_sweep_sequencer

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 32, meaning carrier increment and wishbone data width.
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, meaning step counter width.
REQ-003 SHALL have parameter DWELL_WIDTH, default 24, meaning dwell counter width.
REQ-004 SHALL have parameter ACK_TIMEOUT, default 15, meaning maximum wait cycles for ack after acceptance.
REQ-005 SHALL have parameter CARRIER_ADDR, default 0, meaning wishbone address of the carrier-centre-frequency register.
REQ-006 SHALL have ports, one per line:
i_clk  in  1  sole clock, rising edge; one clock domain.
i_reset  in  1  synchronous, active-high reset.
i_start  in  1  start sweep (level sampled in IDLE).
i_abort  in  1  abort sweep.
i_start_inc  in  ACC_WIDTH  first carrier increment.
i_step_inc  in  ACC_WIDTH  signed per-step delta.
i_num_steps  in  COUNT_WIDTH  number of writes in the sweep.
i_dwell  in  DWELL_WIDTH  idle cycles between ack and next write.
o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  wishbone master control.
o_wb_addr  out  2  always CARRIER_ADDR.
o_wb_data  out  ACC_WIDTH  increment being written.
i_wb_ack, i_wb_stall  in  1 each  wishbone slave response.
o_busy  out  1  high in any state but IDLE.
o_done  out  1  one-cycle pulse on normal completion.
o_error  out  1  sticky ack-timeout flag.
o_step_idx  out  COUNT_WIDTH  index of current/last write.

Function
REQ-007 SHALL implement FSM states IDLE, WRITE, WAIT_ACK, DWELL, DONE.
REQ-008 IDLE: on i_start=1 and i_num_steps!=0 SHALL latch all config inputs, set current increment=i_start_inc, o_step_idx=0, clear o_error, enter WRITE; cyc/stb high the next cycle.
REQ-009 IDLE: on i_start=1 and i_num_steps=0 SHALL enter DONE with no bus cycle.
REQ-010 WRITE: SHALL hold o_wb_cyc=o_wb_stb=o_wb_we=1 with stable addr/data until an edge with i_wb_stall=0 (acceptance), then deassert stb and enter WAIT_ACK, or DONE-path directly if i_wb_ack was high in that same cycle.
REQ-011 WAIT_ACK: o_wb_cyc SHALL stay high until i_wb_ack; ack before acceptance SHALL be ignored.
REQ-012 On ack SHALL drop cyc; if o_step_idx==num_steps-1 enter DONE, else add step delta (mod 2^ACC_WIDTH wrap, no saturation), increment o_step_idx, enter DWELL if dwell!=0 else WRITE.
REQ-013 DWELL: SHALL count exactly latched dwell cycles, then enter WRITE.
REQ-014 Timeout: if ack absent for ACK_TIMEOUT cycles after acceptance, SHALL drop cyc, set o_error=1, return to IDLE without o_done.
REQ-015 DONE: SHALL assert o_done for one cycle, then IDLE.
REQ-016 i_abort in IDLE/DWELL SHALL return to IDLE next cycle; in WRITE/WAIT_ACK the current bus cycle SHALL complete (ack or timeout) then IDLE; no o_done on abort; abort beats start in same cycle.
REQ-017 i_start while busy SHALL be ignored; config input changes while busy SHALL be ignored.

Reset
REQ-018 i_reset SHALL force IDLE and all outputs 0 (cyc, stb, we, data, done, error, busy, step_idx), o_wb_addr=CARRIER_ADDR, mid-transaction included, next cycle.

Structure
REQ-019 Shared package fm_pkg SHALL hold the state enum and register-address constants (carrier=0, modulation freq=1, deviation=2).
REQ-020 One sub-module wb_single_write (one-write wishbone master with timeout) is natural; the FSM stays in fm_sweep_sequencer.

Verification
REQ-021 start_inc=0x444444, step=0x1000, steps=3, dwell=4, zero-stall slave acking 1 cycle later -> writes 0x444444, 0x445444, 0x446444; 4 idle cycles between ack and stb; one o_done.
REQ-022 Slave stall=1 for 3 cycles on write 0 -> stb and data held stable 4 cycles; ack accepted only after acceptance.
REQ-023 start_inc=0xFFFFF000, step=0x2000, steps=2 -> second write 0x00001000 (wrap).
REQ-024 Slave never acks -> cyc drops ACK_TIMEOUT(15) cycles after acceptance, o_error=1, no o_done; next start clears o_error.
REQ-025 steps=0 -> o_done one cycle after start, no cyc; abort during DWELL of step 1 of 5 -> IDLE, no o_done, o_step_idx=1.
REQ-026 i_reset asserted while in WAIT_ACK -> all outputs 0 next cycle, o_busy=0.
